// File: rtl/fp_int_pkg.sv
// Shared number-format constants for the FP x INT multiplier and its accumulator.
package fp_int_pkg;

  localparam int ACC_WIDTH = 32;
  localparam int EXP_WIDTH = 5;
  localparam int MAN_WIDTH = 14;
  localparam int MAN_FRAC  = 13;
  localparam int ACC_FRAC  = 16;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Stage-1 pipeline word: aligned term travelling with its flush bit.
  typedef struct packed {
    logic vld;
    logic flush;
    logic tsat;
    acc_t term;
  } s1_t;

endpackage

// File: rtl/fp_int_align.sv
// Aligns a sign/exponent/mantissa term onto the fixed-point accumulator grid.
// Combinational; clamps magnitude on overflow, truncates toward zero on right shift.
module fp_int_align
  import fp_int_pkg::*;
(
  input  logic                 sign_in,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic [MAN_WIDTH-1:0] mantissa_in,
  output acc_t                 term,
  output logic                 term_sat
);

  localparam int SHIFT_MAX = (1 << (EXP_WIDTH - 1)) - 1 + ACC_FRAC - MAN_FRAC;
  localparam int WIDE_W    = ACC_WIDTH + MAN_WIDTH + SHIFT_MAX;

  int                    shift;
  logic [WIDE_W-1:0]     wide;
  logic [ACC_WIDTH-1:0]  mag;

  always_comb begin
    shift    = int'($signed(exp_in)) + ACC_FRAC - MAN_FRAC;
    wide     = '0;
    mag      = '0;
    term_sat = 1'b0;
    if (shift >= 0) begin
      wide = {{(WIDE_W-MAN_WIDTH){1'b0}}, mantissa_in} << shift;
      // Any bit reaching the sign position or above cannot be represented.
      if (wide[WIDE_W-1:ACC_WIDTH-1] != '0) begin
        term_sat = 1'b1;
        mag      = ACC_MAX;
      end else begin
        mag = wide[ACC_WIDTH-1:0];
      end
    end else if (-shift < MAN_WIDTH) begin
      mag = {{(ACC_WIDTH-MAN_WIDTH){1'b0}}, mantissa_in >> (-shift)};
    end
    term = sign_in ? -mag : mag;
  end

endmodule

// File: rtl/fp_int_acc.sv
// Saturating accumulator of aligned FP x INT terms; result handed out on flush.
// Latency 2 cycles (term/flush -> acc/out_valid); no backpressure, unread results are overwritten and flag overrun.
module fp_int_acc
  import fp_int_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sign_in,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic [MAN_WIDTH-1:0] mantissa_in,
  input  logic                 start_acc,
  input  logic                 flush,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sat,
  output logic                 overrun
);

  acc_t                 term;
  logic                 term_sat;
  s1_t                  s1;
  acc_t                 acc;
  logic                 win_sat;
  acc_t                 addend;
  logic [ACC_WIDTH:0]   sum_wide;
  logic                 add_ovf;
  acc_t                 sum_sat;
  logic                 win_sat_nxt;

  fp_int_align u_align (
    .sign_in     (sign_in),
    .exp_in      (exp_in),
    .mantissa_in (mantissa_in),
    .term        (term),
    .term_sat    (term_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
    end else begin
      s1.vld   <= start_acc;
      s1.flush <= flush;
      s1.tsat  <= start_acc & term_sat;
      s1.term  <= start_acc ? term : '0;
    end
  end

  // Sign-extended add; overflow shows as disagreement of the two top bits.
  always_comb begin
    addend      = s1.vld ? s1.term : '0;
    sum_wide    = {acc[ACC_WIDTH-1], acc} + {addend[ACC_WIDTH-1], addend};
    add_ovf     = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
    sum_sat     = add_ovf ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                          : sum_wide[ACC_WIDTH-1:0];
    win_sat_nxt = win_sat | (s1.vld & (s1.tsat | add_ovf));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      win_sat   <= 1'b0;
      acc_out   <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else if (s1.flush) begin
      acc       <= '0;
      win_sat   <= 1'b0;
      acc_out   <= sum_sat;
      out_sat   <= win_sat_nxt;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end else begin
      acc     <= sum_sat;
      win_sat <= win_sat_nxt;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_int_acc.sv
// Bench for fp_int_acc: directed cases plus a random stream scored against a behavioural model.
module tb_fp_int_acc;

  logic        clk;
  logic        rst;
  logic        sign_in;
  logic [4:0]  exp_in;
  logic [13:0] mantissa_in;
  logic        start_acc;
  logic        flush;
  logic [31:0] acc_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_sat;
  logic        overrun;

  typedef struct packed {
    logic [31:0] acc;
    logic        sat;
  } exp_t;

  exp_t   sb_q[$];
  int     checks;
  int     errors;
  longint m_acc;
  bit     m_sat;

  localparam longint MAX_V = 64'sh7FFF_FFFF;
  localparam longint MIN_V = -64'sh8000_0000;

  fp_int_acc dut (
    .clk         (clk),
    .rst         (rst),
    .sign_in     (sign_in),
    .exp_in      (exp_in),
    .mantissa_in (mantissa_in),
    .start_acc   (start_acc),
    .flush       (flush),
    .acc_out     (acc_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sat     (out_sat),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference value of one term: exact integer scaling, then clamp.
  function automatic longint align_m(input bit sg, input logic [4:0] e,
                                     input logic [13:0] m, output bit sat);
    int     s;
    longint v;
    sat = 1'b0;
    s   = int'($signed(e)) + 3;
    if (m == 0) v = 0;
    else if (s >= 0) begin
      v = longint'(m) << s;
      if (v > MAX_V) begin
        v   = MAX_V;
        sat = 1'b1;
      end
    end else if (-s >= 14) v = 0;
    else v = longint'(m >> (-s));
    return sg ? -v : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit sg, input logic [4:0] e, input logic [13:0] m,
                       input bit tv, input bit fl, input bit keep);
    longint t;
    longint sum;
    bit     ts;
    exp_t   x;
    sign_in     = sg;
    exp_in      = e;
    mantissa_in = m;
    start_acc   = tv;
    flush       = fl;
    if (tv) begin
      t   = align_m(sg, e, m, ts);
      sum = m_acc + t;
      if (sum > MAX_V) begin sum = MAX_V; ts = 1'b1; end
      if (sum < MIN_V) begin sum = MIN_V; ts = 1'b1; end
      m_acc = sum;
      m_sat = m_sat | ts;
    end
    if (fl) begin
      x.acc = m_acc[31:0];
      x.sat = m_sat;
      if (keep) sb_q.push_back(x);
      m_acc = 0;
      m_sat = 1'b0;
    end
    tick();
    start_acc = 1'b0;
    flush     = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      exp_t x;
      check("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        check("sb_acc", acc_out, x.acc);
        check("sb_sat", out_sat, x.sat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; m_acc = 0; m_sat = 1'b0;
    rst = 1'b0; sign_in = 1'b0; exp_in = '0; mantissa_in = '0;
    start_acc = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_acc_out", acc_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    tick();

    // Single term with flush in the same cycle.
    drive(0, 5'd0, 14'h2000, 1, 1, 1);
    check("t1_latency_valid", out_valid, 0);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_acc", acc_out, 32'h0001_0000);
    check("t1_sat", out_sat, 0);
    tick();
    check("t1_valid_drop", out_valid, 0);

    // Negative term.
    drive(1, 5'b11100, 14'h2000, 1, 0, 0);
    drive(0, 5'd0, 14'h0, 0, 1, 1);
    tick();
    check("neg_acc", acc_out, 32'hFFFF_F000);
    tick();

    // Term saturation, then a clean window.
    drive(0, 5'd15, 14'h3FFF, 1, 0, 0);
    drive(0, 5'd0, 14'h0, 0, 1, 1);
    tick();
    check("tsat_acc", acc_out, 32'h7FFF_FFFF);
    check("tsat_sat", out_sat, 1);
    drive(0, 5'd0, 14'h2000, 1, 1, 1);
    tick();
    check("clean_acc", acc_out, 32'h0001_0000);
    check("clean_sat", out_sat, 0);
    tick();

    // Back-to-back windows.
    drive(0, 5'd0,  14'h2000, 1, 0, 0);
    drive(0, 5'd0,  14'h2000, 1, 0, 0);
    drive(1, 5'h1F, 14'h2000, 1, 0, 0);
    drive(0, 5'h1E, 14'h2000, 1, 1, 1);
    drive(0, 5'd0,  14'h2000, 1, 0, 0);
    check("b2b_acc1", acc_out, 32'h0001_C000);
    drive(0, 5'd0, 14'h0, 0, 1, 1);
    tick();
    check("b2b_acc2", acc_out, 32'h0001_0000);
    tick(); tick();

    // Random stream, always-ready sink.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            14'($urandom_range(0, 16383)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, 1);
    end
    drive(0, 5'd0, 14'h0, 0, 1, 1);
    tick(); tick(); tick();
    check("rand_drained", sb_q.size(), 0);

    // Overrun: two windows retire with the sink stalled.
    out_ready = 1'b0;
    drive(0, 5'd0,  14'h2000, 1, 1, 0);
    drive(0, 5'h1E, 14'h2000, 1, 1, 1);
    tick(); tick();
    check("ovr_acc", acc_out, 32'h0000_4000);
    check("ovr_valid", out_valid, 1);
    check("ovr_flag", overrun, 1);
    out_ready = 1'b1;
    tick();
    check("ovr_valid_drop", out_valid, 0);
    check("ovr_sticky", overrun, 1);

    // Reset mid-window.
    drive(0, 5'd0, 14'h2000, 1, 0, 0);
    drive(0, 5'd1, 14'h2000, 1, 0, 0);
    drive(1, 5'd0, 14'h1000, 1, 0, 0);
    rst = 1'b0;
    m_acc = 0;
    m_sat = 1'b0;
    #1;
    check("mid_rst_acc_out", acc_out, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sat", out_sat, 0);
    check("mid_rst_overrun", overrun, 0);
    tick();
    rst = 1'b1;
    drive(0, 5'd0, 14'h2000, 1, 1, 1);
    tick();
    check("post_rst_acc", acc_out, 32'h0001_0000);
    check("post_rst_overrun", overrun, 0);
    tick(); tick();
    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
